// File: rtl/dev_req_arbiter_if.sv
// dev_req_arbiter_if: host request/grant/response bus plus the device
// controller start/done pair shared by dev_req_arbiter.
//   host_req    hosts -> arbiter, level request per host
//   host_gnt    arbiter -> hosts, one-hot registered grant
//   host_done   arbiter -> hosts, one-cycle success pulse
//   host_err    arbiter -> hosts, one-cycle timeout pulse
//   dc_start_en arbiter -> device controller, one-cycle start pulse
//   dc_done_in  device controller -> arbiter, completion
//   arb_busy    arbiter status, high whenever not idle
//   cur_host    index of the granted host, 0 when idle
// modport master: arbiter side. modport slave: hosts/device side.
interface dev_req_arbiter_if #(
  parameter int NUM_HOST = 4
);
  localparam int HW = (NUM_HOST > 1) ? $clog2(NUM_HOST) : 1;

  logic [NUM_HOST-1:0] host_req;
  logic [NUM_HOST-1:0] host_gnt;
  logic [NUM_HOST-1:0] host_done;
  logic [NUM_HOST-1:0] host_err;
  logic                dc_start_en;
  logic                dc_done_in;
  logic                arb_busy;
  logic [HW-1:0]       cur_host;

  modport master (
    input  host_req, dc_done_in,
    output host_gnt, host_done, host_err, dc_start_en, arb_busy, cur_host
  );

  modport slave (
    output host_req, dc_done_in,
    input  host_gnt, host_done, host_err, dc_start_en, arb_busy, cur_host
  );
endinterface

// File: rtl/dev_req_arbiter.sv
// dev_req_arbiter: round-robin arbiter/sequencer sharing one device read
// controller between NUM_HOST hosts. IDLE picks the next requester after
// the last served host, GRANT pulses dc_start_en, WAIT waits for dc_done_in
// under a TIMEOUT-cycle watchdog, RESP pulses host_done or host_err, then
// the pointer moves past the served host. All outputs are registered.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (aborts any transaction silently)
//   bus  dev_req_arbiter_if.master (host req/gnt/done/err, dc start/done,
//        arb_busy, cur_host)
module dev_req_arbiter #(
  parameter int NUM_HOST = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  dev_req_arbiter_if.master bus
);
  localparam int HW = (NUM_HOST > 1) ? $clog2(NUM_HOST) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [NUM_HOST-1:0] gnt_q, gnt_d;
  logic [NUM_HOST-1:0] done_q, done_d;
  logic [NUM_HOST-1:0] err_q, err_d;
  logic [HW-1:0]       cur_q, cur_d;
  logic [HW-1:0]       last_q, last_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;

  logic [HW-1:0]       win;
  logic                found;
  logic [HW-1:0]       idx_v;
  int                  idx;

  // Round-robin scan: last+1, last+2, ... wrapping at NUM_HOST, first hit wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    idx_v = '0;
    for (int i = 1; i <= NUM_HOST; i++) begin
      idx   = (int'(last_q) + i) % NUM_HOST;
      idx_v = HW'(idx);
      if (!found && bus.host_req[idx_v]) begin
        win   = idx_v;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cur_d   = cur_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    done_d  = '0;
    err_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = NUM_HOST'(1) << win;
          cur_d   = win;
          start_d = 1'b1;
        end
      end
      GRANT: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // done is checked first so a completion on the final watchdog
        // cycle still counts as success
        if (bus.dc_done_in) begin
          state_d = RESP;
          done_d  = gnt_q;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = RESP;
          err_d   = gnt_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        gnt_d   = '0;
        cur_d   = '0;
        last_d  = cur_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      cur_q   <= '0;
      last_q  <= HW'(NUM_HOST - 1);
      cnt_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.host_gnt    = gnt_q;
  assign bus.host_done   = done_q;
  assign bus.host_err    = err_q;
  assign bus.dc_start_en = start_q;
  assign bus.arb_busy    = busy_q;
  assign bus.cur_host    = cur_q;
endmodule
